// File: rtl/ps2_pkg.sv
// Shared constants and helpers for PS/2 mouse packet assembly: FSM encoding,
// register addresses, status-byte bit positions and the delta formatter.
package ps2_pkg;

  localparam logic [1:0] S_B0 = 2'd0;
  localparam logic [1:0] S_B1 = 2'd1;
  localparam logic [1:0] S_B2 = 2'd2;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_X      = 2'd1;
  localparam logic [1:0] ADDR_Y      = 2'd2;
  localparam logic [1:0] ADDR_CNT    = 2'd3;

  localparam int BIT_LEFT    = 0;
  localparam int BIT_RIGHT   = 1;
  localparam int BIT_ALWAYS1 = 3;
  localparam int BIT_XSIGN   = 4;
  localparam int BIT_YSIGN   = 5;
  localparam int BIT_XOVF    = 6;
  localparam int BIT_YOVF    = 7;

  typedef struct packed {
    logic [8:0] status;
    logic [8:0] x;
    logic [8:0] y;
  } bank_t;

  // Overflowed deltas clamp to the extreme of their sign instead of wrapping.
  function automatic logic [8:0] fmt_delta(input logic sign, input logic ovf,
                                           input logic [7:0] raw, input logic sat);
    logic [8:0] r;
    r = {sign, raw};
    if (sat && ovf) begin
      r = sign ? 9'h100 : 9'h0FF;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_gap_timer.sv
// Inter-byte gap timer: counts enabled idle cycles, pulses expire on the GAP_CYCLES-th.
// A clear (new byte) in the same cycle wins over expiry; no backpressure.
module ps2_gap_timer #(
  parameter int GAP_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = en & ~clr & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 mouse packets into a frozen, readable register bank.
// Byte 2 to dav is 2 cycles when not holding; input is never backpressured (newest packet wins).
module ps2_mouse_packet
  import ps2_pkg::*;
#(
  parameter int GAP_CYCLES  = 50000,
  parameter int HOLD_CYCLES = 4,
  parameter bit SAT_OVF     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic [1:0] addr,
  output logic [8:0] data,
  output logic       dav,
  output logic       sync_err
);

  localparam int HW = $clog2(HOLD_CYCLES + 2);

  logic [1:0]    state_q, state_d;
  logic [7:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  bank_t         pend_q, pend_d;
  bank_t         pub_q, pub_d;
  logic          pending_q, pending_d;
  logic [8:0]    count_q, count_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          dav_q, dav_d;
  logic          sync_err_q, sync_err_d;

  logic  gap_en;
  logic  gap_expire;
  logic  pkt_done;
  logic  pub_go;
  bank_t new_pkt;

  assign gap_en = (state_q == S_B1) || (state_q == S_B2);

  ps2_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_valid | rx_err),
    .en     (gap_en),
    .expire (gap_expire)
  );

  // Assembly FSM; an errored byte is dropped even if rx_valid accompanies it.
  always_comb begin
    state_d    = state_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    sync_err_d = 1'b0;
    pkt_done   = 1'b0;
    if (rx_err) begin
      state_d    = S_B0;
      sync_err_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        S_B0: begin
          if (rx_data[BIT_ALWAYS1]) begin
            b0_d    = rx_data;
            state_d = S_B1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
        S_B1: begin
          b1_d    = rx_data;
          state_d = S_B2;
        end
        S_B2: begin
          pkt_done = 1'b1;
          state_d  = S_B0;
        end
        default: state_d = S_B0;
      endcase
    end else if (gap_expire) begin
      state_d    = S_B0;
      sync_err_d = 1'b1;
    end
  end

  always_comb begin
    new_pkt.status = {1'b0, b0_q};
    new_pkt.x      = fmt_delta(b0_q[BIT_XSIGN], b0_q[BIT_XOVF], b1_q, SAT_OVF);
    new_pkt.y      = fmt_delta(b0_q[BIT_YSIGN], b0_q[BIT_YOVF], rx_data, SAT_OVF);
  end

  assign pub_go = pending_q && (hold_q == '0);

  // Publish reads the old pending bank, so a packet completing now is never lost.
  always_comb begin
    pend_d    = pend_q;
    pending_d = pending_q;
    pub_d     = pub_q;
    count_d   = count_q;
    hold_d    = hold_q;
    dav_d     = pub_go;
    if (pub_go) begin
      pub_d     = pend_q;
      count_d   = count_q + 9'd1;
      hold_d    = HW'(HOLD_CYCLES);
      pending_d = 1'b0;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
    if (pkt_done) begin
      pend_d    = new_pkt;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_B0;
      b0_q       <= '0;
      b1_q       <= '0;
      pend_q     <= '0;
      pub_q      <= '0;
      pending_q  <= 1'b0;
      count_q    <= '0;
      hold_q     <= '0;
      dav_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      pend_q     <= pend_d;
      pub_q      <= pub_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      dav_q      <= dav_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    data = '0;
    case (addr)
      ADDR_STATUS: data = pub_q.status;
      ADDR_X:      data = pub_q.x;
      ADDR_Y:      data = pub_q.y;
      ADDR_CNT:    data = count_q;
      default:     data = '0;
    endcase
  end

  assign dav      = dav_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed bench for ps2_mouse_packet: packet assembly, resync, saturation,
// gap timeout, publish hold and mid-packet reset.
module tb_ps2_mouse_packet;

  localparam int GAP  = 200;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [8:0] data;
  logic       dav;
  logic       sync_err;

  int errors = 0;
  int checks = 0;
  int sync_cnt = 0;
  int dav_cnt = 0;

  ps2_mouse_packet #(
    .GAP_CYCLES (GAP),
    .HOLD_CYCLES(HOLD),
    .SAT_OVF    (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .addr     (addr),
    .data     (data),
    .dav      (dav),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sync_err === 1'b1) sync_cnt++;
    if (dav === 1'b1) dav_cnt++;
  end

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; the byte is sampled on the next posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [8:0] v);
    addr = a;
    #1;
    v = data;
  endtask

  task automatic wait_dav(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (dav === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      checks++; errors++;
      $display("FAIL dav_timeout: dav not seen within 50 cycles");
    end
  endtask

  task automatic test_reset();
    logic [8:0] v;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      checks++;
      if (v !== 9'h000) begin errors++; $display("FAIL reset_addr%0d: got %03h expected 000", a, v); end
    end
    checks++;
    if (dav !== 1'b0) begin errors++; $display("FAIL reset_dav: got %b expected 0", dav); end
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
  endtask

  task automatic test_basic();
    logic [8:0] v;
    int cyc;
    do_reset();
    send_byte(8'h28); send_byte(8'h05); send_byte(8'hFB);
    wait_dav(cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL basic_latency: got %0d expected 1", cyc); end
    rd(2'd0, v); checks++;
    if (v !== 9'h028) begin errors++; $display("FAIL basic_status: got %03h expected 028", v); end
    rd(2'd1, v); checks++;
    if (v !== 9'h005) begin errors++; $display("FAIL basic_x: got %03h expected 005", v); end
    rd(2'd2, v); checks++;
    if (v !== 9'h1FB) begin errors++; $display("FAIL basic_y: got %03h expected 1FB", v); end
    rd(2'd3, v); checks++;
    if (v !== 9'h001) begin errors++; $display("FAIL basic_count: got %03h expected 001", v); end
    @(negedge clk);
    checks++;
    if (dav !== 1'b0) begin errors++; $display("FAIL basic_dav_width: got %b expected 0", dav); end
  endtask

  task automatic test_resync();
    logic [8:0] v;
    int cyc, s0;
    do_reset();
    s0 = sync_cnt;
    send_byte(8'h05);
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL resync_pulse: got %b expected 1", sync_err); end
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    wait_dav(cyc);
    rd(2'd0, v); checks++;
    if (v !== 9'h008) begin errors++; $display("FAIL resync_status: got %03h expected 008", v); end
    rd(2'd1, v); checks++;
    if (v !== 9'h001) begin errors++; $display("FAIL resync_x: got %03h expected 001", v); end
    rd(2'd2, v); checks++;
    if (v !== 9'h002) begin errors++; $display("FAIL resync_y: got %03h expected 002", v); end
    checks++;
    if (sync_cnt - s0 !== 1) begin errors++; $display("FAIL resync_count: got %0d pulses expected 1", sync_cnt - s0); end
  endtask

  task automatic test_saturate();
    logic [7:0] b0 [4] = '{8'h48, 8'hD8, 8'hF8, 8'h38};
    logic [7:0] b1 [4] = '{8'h00, 8'h00, 8'h7F, 8'hFF};
    logic [7:0] b2 [4] = '{8'h00, 8'h00, 8'h80, 8'h80};
    logic [8:0] ex [4] = '{9'h0FF, 9'h100, 9'h100, 9'h1FF};
    logic [8:0] ey [4] = '{9'h000, 9'h0FF, 9'h100, 9'h180};
    logic [8:0] v;
    int cyc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_byte(b0[i]); send_byte(b1[i]); send_byte(b2[i]);
      wait_dav(cyc);
      rd(2'd1, v); checks++;
      if (v !== ex[i]) begin errors++; $display("FAIL sat_x%0d: got %03h expected %03h", i, v, ex[i]); end
      rd(2'd2, v); checks++;
      if (v !== ey[i]) begin errors++; $display("FAIL sat_y%0d: got %03h expected %03h", i, v, ey[i]); end
    end
  endtask

  task automatic test_gap();
    logic [8:0] v;
    int cyc, s0;
    do_reset();
    s0 = sync_cnt;
    send_byte(8'h28); send_byte(8'h05);
    cyc = 0;
    for (int i = 1; i <= GAP + 20; i++) begin
      @(negedge clk);
      if (sync_err === 1'b1) begin cyc = i; break; end
    end
    checks++;
    if (cyc !== GAP) begin errors++; $display("FAIL gap_timeout: sync_err after %0d cycles expected %0d", cyc, GAP); end
    send_byte(8'h08); send_byte(8'h03); send_byte(8'h04);
    wait_dav(cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL gap_latency: got %0d expected 1", cyc); end
    rd(2'd1, v); checks++;
    if (v !== 9'h003) begin errors++; $display("FAIL gap_x: got %03h expected 003", v); end
    rd(2'd2, v); checks++;
    if (v !== 9'h004) begin errors++; $display("FAIL gap_y: got %03h expected 004", v); end
    rd(2'd3, v); checks++;
    if (v !== 9'h001) begin errors++; $display("FAIL gap_count: got %03h expected 001", v); end
    checks++;
    if (sync_cnt - s0 !== 1) begin errors++; $display("FAIL gap_sync_count: got %0d expected 1", sync_cnt - s0); end
  endtask

  task automatic test_hold();
    logic [8:0] v;
    logic [8:0] p1 [3] = '{9'h028, 9'h005, 9'h1FB};
    logic [7:0] p2b [3] = '{8'h08, 8'h03, 8'h04};
    int cyc, d0;
    do_reset();
    d0 = dav_cnt;
    send_byte(8'h28); send_byte(8'h05); send_byte(8'hFB);
    for (int k = 0; k < 3; k++) begin
      send_byte(p2b[k]);
      checks++;
      if (dav !== (k == 0)) begin errors++; $display("FAIL hold_dav%0d: got %b expected %b", k, dav, k == 0); end
      for (int a = 0; a < 3; a++) begin
        rd(a[1:0], v); checks++;
        if (v !== p1[a]) begin errors++; $display("FAIL hold_frozen%0d_addr%0d: got %03h expected %03h", k, a, v, p1[a]); end
      end
    end
    wait_dav(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL hold_delay: got %0d expected 3", cyc); end
    rd(2'd1, v); checks++;
    if (v !== 9'h003) begin errors++; $display("FAIL hold_x2: got %03h expected 003", v); end
    rd(2'd2, v); checks++;
    if (v !== 9'h004) begin errors++; $display("FAIL hold_y2: got %03h expected 004", v); end
    rd(2'd3, v); checks++;
    if (v !== 9'h002) begin errors++; $display("FAIL hold_count: got %03h expected 002", v); end
    checks++;
    if (dav_cnt - d0 !== 2) begin errors++; $display("FAIL hold_dav_pulses: got %0d expected 2", dav_cnt - d0); end
  endtask

  task automatic test_mid_reset();
    logic [8:0] v;
    int cyc, s0, d0;
    send_byte(8'h28); send_byte(8'h05);
    rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v); checks++;
      if (v !== 9'h000) begin errors++; $display("FAIL mrst_addr%0d: got %03h expected 000", a, v); end
    end
    @(negedge clk);
    rst = 1'b0;
    s0 = sync_cnt;
    d0 = dav_cnt;
    repeat (2) @(negedge clk);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h01);
    wait_dav(cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL mrst_latency: got %0d expected 1", cyc); end
    rd(2'd1, v); checks++;
    if (v !== 9'h001) begin errors++; $display("FAIL mrst_x: got %03h expected 001", v); end
    rd(2'd3, v); checks++;
    if (v !== 9'h001) begin errors++; $display("FAIL mrst_count: got %03h expected 001", v); end
    checks++;
    if (sync_cnt - s0 !== 0) begin errors++; $display("FAIL mrst_sync: got %0d pulses expected 0", sync_cnt - s0); end
    checks++;
    if (dav_cnt - d0 !== 1) begin errors++; $display("FAIL mrst_dav_pulses: got %0d expected 1", dav_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_resync();
    test_saturate();
    test_gap();
    test_hold();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
